// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller with RUN/FLUSH/MEMWAIT sequencing.
// Define ID_HAZARD_PERF_EN to build the saturating stall/flush counters.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       IfId_AddrRs,
  input  logic [4:0]       IfId_AddrRt,
  input  logic             IfId_UsesRt,
  input  logic             IdEx_RegWrite,
  input  logic             IdEx_MemRead,
  input  logic [4:0]       IdEx_WrAddr,
  input  logic             ExMem_RegWrite,
  input  logic             ExMem_MemRead,
  input  logic [4:0]       ExMem_WrAddr,
  input  logic             MemWb_RegWrite,
  input  logic [4:0]       MemWb_WrAddr,
  input  logic             Branch_Taken,
  input  logic             Jump,
  input  logic             Mem_Busy,
  output logic             Stall,
  output logic             PC_Hold,
  output logic             IfId_Hold,
  output logic             IfId_Flush,
  output logic             Pipe_Freeze,
  output logic [1:0]       Fwd_IfId_Rs,
  output logic [1:0]       Fwd_IfId_Rt,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

  state_t state, state_nxt;
  logic   rs_idex, rt_idex, rs_exmem, rt_exmem, rs_memwb, rt_memwb;
  logic   haz, redirect;

  function automatic logic src_match(input logic we, input logic [4:0] wa,
                                     input logic [4:0] src);
    return we && (wa == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit && !ExMem_MemRead) return 2'b10;
    else if (memwb_hit)              return 2'b01;
    else                             return 2'b00;
  endfunction

  // Rt only participates when the decode instruction actually reads it.
  assign rs_idex  = src_match(IdEx_RegWrite,  IdEx_WrAddr,  IfId_AddrRs);
  assign rt_idex  = src_match(IdEx_RegWrite,  IdEx_WrAddr,  IfId_AddrRt) && IfId_UsesRt;
  assign rs_exmem = src_match(ExMem_RegWrite, ExMem_WrAddr, IfId_AddrRs);
  assign rt_exmem = src_match(ExMem_RegWrite, ExMem_WrAddr, IfId_AddrRt) && IfId_UsesRt;
  assign rs_memwb = src_match(MemWb_RegWrite, MemWb_WrAddr, IfId_AddrRs);
  assign rt_memwb = src_match(MemWb_RegWrite, MemWb_WrAddr, IfId_AddrRt) && IfId_UsesRt;

  // A load still in EX/MEM has no data to forward yet, so it stalls too.
  assign haz      = rs_idex || rt_idex || ((rs_exmem || rt_exmem) && ExMem_MemRead);
  assign redirect = Branch_Taken || Jump;

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (Mem_Busy)      state_nxt = MEMWAIT;
        else if (haz)      state_nxt = RUN;
        else if (redirect) state_nxt = FLUSH;
        else               state_nxt = RUN;
      end
      FLUSH:   state_nxt = Mem_Busy ? MEMWAIT : RUN;
      MEMWAIT: state_nxt = Mem_Busy ? MEMWAIT : RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    Stall       = 1'b0;
    PC_Hold     = 1'b0;
    IfId_Hold   = 1'b0;
    IfId_Flush  = 1'b0;
    Pipe_Freeze = 1'b0;
    if (RST) begin
      Stall     = 1'b1;
      PC_Hold   = 1'b1;
      IfId_Hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (!Mem_Busy && haz) begin
            Stall     = 1'b1;
            PC_Hold   = 1'b1;
            IfId_Hold = 1'b1;
          end else if (!Mem_Busy && redirect) begin
            IfId_Flush = 1'b1;
          end
        end
        FLUSH: begin
          if (!Mem_Busy && haz) begin
            Stall     = 1'b1;
            PC_Hold   = 1'b1;
            IfId_Hold = 1'b1;
          end
        end
        MEMWAIT: begin
          Pipe_Freeze = 1'b1;
          PC_Hold     = 1'b1;
          IfId_Hold   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Fwd_IfId_Rs = Stall ? 2'b00 : fwd_sel(rs_exmem, rs_memwb);
  assign Fwd_IfId_Rt = Stall ? 2'b00 : fwd_sel(rt_exmem, rt_memwb);

`ifdef ID_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Stall || Pipe_Freeze) stall_cnt <= sat_inc(stall_cnt);
      if (IfId_Flush)           flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign Stall_Cnt = stall_cnt;
  assign Flush_Cnt = flush_cnt;
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed test-plan sequences plus random
// traffic, checked against a rule-level reference model of the controller.
module tb_id_hazard_ctrl;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [4:0]    IfId_AddrRs, IfId_AddrRt, IdEx_WrAddr, ExMem_WrAddr, MemWb_WrAddr;
  logic          IfId_UsesRt, IdEx_RegWrite, IdEx_MemRead, ExMem_RegWrite, ExMem_MemRead;
  logic          MemWb_RegWrite, Branch_Taken, Jump, Mem_Busy;
  logic          Stall, PC_Hold, IfId_Hold, IfId_Flush, Pipe_Freeze;
  logic [1:0]    Fwd_IfId_Rs, Fwd_IfId_Rt;
  logic [CW-1:0] Stall_Cnt, Flush_Cnt;

  id_hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .IfId_AddrRs(IfId_AddrRs), .IfId_AddrRt(IfId_AddrRt), .IfId_UsesRt(IfId_UsesRt),
    .IdEx_RegWrite(IdEx_RegWrite), .IdEx_MemRead(IdEx_MemRead), .IdEx_WrAddr(IdEx_WrAddr),
    .ExMem_RegWrite(ExMem_RegWrite), .ExMem_MemRead(ExMem_MemRead), .ExMem_WrAddr(ExMem_WrAddr),
    .MemWb_RegWrite(MemWb_RegWrite), .MemWb_WrAddr(MemWb_WrAddr),
    .Branch_Taken(Branch_Taken), .Jump(Jump), .Mem_Busy(Mem_Busy),
    .Stall(Stall), .PC_Hold(PC_Hold), .IfId_Hold(IfId_Hold), .IfId_Flush(IfId_Flush),
    .Pipe_Freeze(Pipe_Freeze), .Fwd_IfId_Rs(Fwd_IfId_Rs), .Fwd_IfId_Rt(Fwd_IfId_Rt),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic       idex_we, idex_mr;
    logic [4:0] idex_wa;
    logic       exmem_we, exmem_mr;
    logic [4:0] exmem_wa;
    logic       memwb_we;
    logic [4:0] memwb_wa;
    logic       br, jmp, busy;
  } stim_t;

  // {Stall, PC_Hold, IfId_Hold, IfId_Flush, Pipe_Freeze, FwdRs, FwdRt, StallCnt, FlushCnt}
  typedef logic [8+2*CW:0] resp_t;

  resp_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    done = 0;

  // Reference model: 0 = normal, 1 = cycle after a flush, 2 = waiting on memory
  int mode = 0;
  int m_scnt = 0, m_fcnt = 0;

  function automatic bit hit(input logic we, input logic [4:0] wa, input logic [4:0] src);
    return (we == 1'b1) && (src != 0) && (wa == src);
  endfunction

  task automatic apply(input stim_t s);
    bit rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb, haz;
    bit e_stall, e_hold, e_flush, e_frz;
    logic [1:0] e_frs, e_frt;
    logic [CW-1:0] e_sc, e_fc;
    @(posedge CLK);
    #1;
    RST = s.rst; IfId_AddrRs = s.rs; IfId_AddrRt = s.rt; IfId_UsesRt = s.uses_rt;
    IdEx_RegWrite = s.idex_we; IdEx_MemRead = s.idex_mr; IdEx_WrAddr = s.idex_wa;
    ExMem_RegWrite = s.exmem_we; ExMem_MemRead = s.exmem_mr; ExMem_WrAddr = s.exmem_wa;
    MemWb_RegWrite = s.memwb_we; MemWb_WrAddr = s.memwb_wa;
    Branch_Taken = s.br; Jump = s.jmp; Mem_Busy = s.busy;

    rs_ex  = hit(s.idex_we, s.idex_wa, s.rs);
    rt_ex  = s.uses_rt && hit(s.idex_we, s.idex_wa, s.rt);
    rs_mem = hit(s.exmem_we, s.exmem_wa, s.rs);
    rt_mem = s.uses_rt && hit(s.exmem_we, s.exmem_wa, s.rt);
    rs_wb  = hit(s.memwb_we, s.memwb_wa, s.rs);
    rt_wb  = s.uses_rt && hit(s.memwb_we, s.memwb_wa, s.rt);
    haz    = rs_ex || rt_ex || (s.exmem_mr && (rs_mem || rt_mem));

    e_frz   = !s.rst && mode == 2;
    e_stall = s.rst || (mode != 2 && !s.busy && haz);
    e_hold  = e_stall || e_frz;
    e_flush = !s.rst && mode == 0 && !s.busy && !haz && (s.br || s.jmp);

    e_frs = 2'b00;
    e_frt = 2'b00;
    if (!e_stall) begin
      if (rs_mem && !s.exmem_mr) e_frs = 2'b10; else if (rs_wb) e_frs = 2'b01;
      if (rt_mem && !s.exmem_mr) e_frt = 2'b10; else if (rt_wb) e_frt = 2'b01;
    end
`ifdef ID_HAZARD_PERF_EN
    e_sc = CW'(m_scnt);
    e_fc = CW'(m_fcnt);
`else
    e_sc = '0;
    e_fc = '0;
`endif
    exp_q.push_back({e_stall, e_hold, e_hold, e_flush, e_frz, e_frs, e_frt, e_sc, e_fc});

    // Advance the model across the coming clock edge
    if (s.rst) begin
      mode = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if ((e_stall || e_frz) && m_scnt < CMAX) m_scnt++;
      if (e_flush && m_fcnt < CMAX) m_fcnt++;
      if (s.busy)      mode = 2;
      else if (e_flush) mode = 1;
      else             mode = 0;
    end
  endtask

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst      = ($urandom_range(0, 63) == 0);
    s.rs       = 5'($urandom_range(0, 3));
    s.rt       = 5'($urandom_range(0, 3));
    s.uses_rt  = 1'($urandom);
    s.idex_we  = 1'($urandom);
    s.idex_mr  = ($urandom_range(0, 2) == 0);
    s.idex_wa  = 5'($urandom_range(0, 3));
    s.exmem_we = 1'($urandom);
    s.exmem_mr = ($urandom_range(0, 2) == 0);
    s.exmem_wa = 5'($urandom_range(0, 3));
    s.memwb_we = 1'($urandom);
    s.memwb_wa = 5'($urandom_range(0, 3));
    s.br       = ($urandom_range(0, 3) == 0);
    s.jmp      = ($urandom_range(0, 7) == 0);
    s.busy     = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    resp_t e, got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {Stall, PC_Hold, IfId_Hold, IfId_Flush, Pipe_Freeze,
               Fwd_IfId_Rs, Fwd_IfId_Rt, Stall_Cnt, Flush_Cnt};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL vec %0d ctrl{stall,pch,ifh,flush,frz,rs,rt,scnt,fcnt}: got %b expected %b",
                   vectors, got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: bench did not complete, %0d responses pending", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    stim_t s;
    s = nop(); s.rst = 1'b1;
    RST = 1'b1; IfId_AddrRs = '0; IfId_AddrRt = '0; IfId_UsesRt = 1'b0;
    IdEx_RegWrite = 1'b0; IdEx_MemRead = 1'b0; IdEx_WrAddr = '0;
    ExMem_RegWrite = 1'b0; ExMem_MemRead = 1'b0; ExMem_WrAddr = '0;
    MemWb_RegWrite = 1'b0; MemWb_WrAddr = '0;
    Branch_Taken = 1'b0; Jump = 1'b0; Mem_Busy = 1'b0;
    apply(s);
    apply(s);

    // Load-use: lw $5 ; add $6,$5,$7
    s = nop(); s.rs = 5; s.rt = 7; s.uses_rt = 1; s.idex_we = 1; s.idex_mr = 1; s.idex_wa = 5;
    apply(s);
    s.idex_we = 0; s.idex_mr = 0; s.exmem_we = 1; s.exmem_mr = 1; s.exmem_wa = 5;
    apply(s);
    s.exmem_we = 0; s.exmem_mr = 0; s.memwb_we = 1; s.memwb_wa = 5;
    apply(s);

    // ALU chain: add $3 ; sub $4,$3,$3, then the same with Rt unused
    for (int u = 1; u >= 0; u--) begin
      s = nop(); s.rs = 3; s.rt = 3; s.uses_rt = 1'(u); s.idex_we = 1; s.idex_wa = 3;
      apply(s);
      s.idex_we = 0; s.exmem_we = 1; s.exmem_wa = 3;
      apply(s);
    end

    // Priority EX/MEM over MEM/WB on $9, then a $0 dependency
    s = nop(); s.rs = 9; s.rt = 9; s.uses_rt = 1; s.exmem_we = 1; s.exmem_wa = 9;
    s.memwb_we = 1; s.memwb_wa = 9;
    apply(s);
    s = nop(); s.uses_rt = 1; s.idex_we = 1; s.idex_mr = 1; s.exmem_we = 1; s.memwb_we = 1;
    apply(s);

    // Branch held high through FLUSH, then a jump
    s = nop(); s.br = 1;
    apply(s); apply(s); apply(s);
    s = nop(); s.jmp = 1;
    apply(s);
    apply(nop());

    // Branch taken while a hazard is pending
    s = nop(); s.rs = 2; s.idex_we = 1; s.idex_wa = 2; s.br = 1;
    apply(s);
    s.idex_we = 0; s.exmem_we = 1; s.exmem_wa = 2;
    apply(s);
    apply(nop());

    // Mem_Busy for 3 cycles in the middle of a load-use stall
    s = nop(); s.rs = 5; s.idex_we = 1; s.idex_mr = 1; s.idex_wa = 5;
    apply(s);
    s.idex_we = 0; s.idex_mr = 0; s.exmem_we = 1; s.exmem_mr = 1; s.exmem_wa = 5; s.busy = 1;
    apply(s); apply(s); apply(s);
    s.busy = 0;
    apply(s); apply(s);
    s.exmem_we = 0; s.exmem_mr = 0; s.memwb_we = 1; s.memwb_wa = 5;
    apply(s);

    // Reset during MEMWAIT and during FLUSH
    s = nop(); s.busy = 1;
    apply(s); apply(s);
    s = nop(); s.rst = 1;
    apply(s);
    apply(nop());
    s = nop(); s.br = 1;
    apply(s);
    s.rst = 1;
    apply(s);
    apply(nop());

    // Drive both counters into saturation
    s = nop(); s.rs = 1; s.idex_we = 1; s.idex_wa = 1;
    repeat (CMAX + 3) apply(s);
    for (int i = 0; i < CMAX + 3; i++) begin
      s = nop(); s.br = 1;
      apply(s);
      apply(nop());
    end

    repeat (500) apply(rnd());

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and forwarding controller for the decode stage. Each cycle it compares the IF/ID source registers against the destinations in ID/EX, EX/MEM and MEM/WB, and drives four things: the decode-stage forwarding selects, the bubble-insert `Stall`, the PC and IF/ID holds, and the IF/ID flush for taken branches and jumps. A small FSM sequences branch flushes and whole-pipeline freezes during multi-cycle memory waits. Optional counters record stall and flush cycles.

## Interface
Parameters:
- `CNT_W`, 16, width of the performance counters.

Ports:
- `CLK`, input, 1, the only clock; all state changes on its rising edge.
- `RST`, input, 1, synchronous reset, active-high.
- `IfId_AddrRs`, `IfId_AddrRt`, input, 5 each, source registers of the instruction in decode.
- `IfId_UsesRt`, input, 1, decode instruction reads Rt (R-type, store, branch).
- `IdEx_RegWrite`, `IdEx_MemRead`, input, 1 each, ID/EX control bits.
- `IdEx_WrAddr`, input, 5, ID/EX destination (already RegDst-muxed).
- `ExMem_RegWrite`, `ExMem_MemRead`, input, 1 each, EX/MEM control bits.
- `ExMem_WrAddr`, input, 5, EX/MEM destination.
- `MemWb_RegWrite`, input, 1, MEM/WB control bit.
- `MemWb_WrAddr`, input, 5, MEM/WB destination.
- `Branch_Taken`, `Jump`, input, 1 each, decode-stage redirect (PCT selected).
- `Mem_Busy`, input, 1, data memory not ready; the pipeline must freeze.
- `Stall`, output, 1, zero the ID/EX controls (bubble).
- `PC_Hold`, `IfId_Hold`, output, 1 each, hold PC and IF/ID.
- `IfId_Flush`, output, 1, clear IF/ID to a NOP at the next edge.
- `Pipe_Freeze`, output, 1, hold ID/EX, EX/MEM and MEM/WB.
- `Fwd_IfId_Rs`, `Fwd_IfId_Rt`, output, 2 each, select for the decode mux3x1: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- `Stall_Cnt`, `Flush_Cnt`, output, `CNT_W` each, performance counters.

## Operation
Match rules:
- A source matches a stage when that stage has RegWrite=1, its WrAddr equals the source, and the source is nonzero.
- Rt is considered only when `IfId_UsesRt`=1.

Hazard (combinational):
- `haz` = (either source matches ID/EX) OR (either source matches EX/MEM with `ExMem_MemRead`=1).
- Reason: load data is not yet available at EX/MEM.

Forwarding, per source:
- Select 10 if it matches EX/MEM and `ExMem_MemRead`=0.
- Otherwise select 01 if it matches MEM/WB.
- Otherwise select 00.
- EX/MEM has priority over MEM/WB.
- Both selects are forced to 00 whenever `Stall`=1.

FSM, states RUN, FLUSH, MEMWAIT:
- **RUN**
  - If `Mem_Busy`=1, go to MEMWAIT.
  - Otherwise, if `haz`=1: `Stall`=`PC_Hold`=`IfId_Hold`=1, stay in RUN. `Branch_Taken`/`Jump` are ignored because the branch operands are not valid yet.
  - Otherwise, if `Branch_Taken` or `Jump`: `IfId_Flush`=1, go to FLUSH.
  - Otherwise all controls are 0.
- **FLUSH** (one cycle; IF/ID holds the NOP)
  - Redirect inputs are ignored, so no double flush.
  - Hazard logic stays active; it never matches in practice because the NOP has RegWrite=0.
  - Go to RUN, or to MEMWAIT if `Mem_Busy`=1.
- **MEMWAIT**
  - `Pipe_Freeze`=`PC_Hold`=`IfId_Hold`=1; `Stall`=0; `IfId_Flush`=0.
  - Go to RUN on the first cycle with `Mem_Busy`=0.

Priority of events: `Mem_Busy` > `haz` > redirect.

## Timing
Reset:
- `RST`=1 at an edge puts the FSM in RUN and clears both counters.
- While `RST`=1: `Stall`, `PC_Hold`, `IfId_Hold` = 1; `IfId_Flush`, `Pipe_Freeze` = 0; `Fwd_*` = 00.
- Reset mid-MEMWAIT or mid-FLUSH aborts the sequence; there is no residual flush.

Latency:
- `haz`, forwarding selects and all holds are combinational from the inputs and current state. They take effect at the same rising edge.
- State, and therefore `Pipe_Freeze` entry, updates one edge after `Mem_Busy` rises. The memory must assert `Mem_Busy` in the cycle it cannot complete.

Stall sequences:
- Load in ID/EX with a dependent instruction in decode: 2 stall cycles, then select 01.
- ALU producer in ID/EX: 1 stall cycle, then select 10.
- Producer in EX/MEM (non-load): 0 stalls, select 10.

Counters:
- `Stall_Cnt` increments on each edge with `Stall`=1 or `Pipe_Freeze`=1.
- `Flush_Cnt` increments on each edge with `IfId_Flush`=1.
- Both saturate at all-ones; there is no wrap-around.

## Configuration
- `ID_HAZARD_PERF_EN` defined: both counters are implemented as above.
- Not defined: no counter flops; `Stall_Cnt` and `Flush_Cnt` are tied to 0.

## Test plan
- Load-use: `lw $5` followed by `add $6,$5,$7` → `Stall`=1 for 2 cycles, then `Fwd_IfId_Rs`=01; `Stall_Cnt`=2.
- ALU chain: `add $3` followed by `sub $4,$3,$3` → 1 stall cycle, then `Fwd_IfId_Rs`=`Fwd_IfId_Rt`=10. With `IfId_UsesRt`=0, `Fwd_IfId_Rt`=00.
- Priority: `$9` written in both EX/MEM (ALU) and MEM/WB → select 10. Dependency on `$0` → no stall, select 00.
- Branch taken with no hazard → `IfId_Flush`=1 for exactly 1 cycle. A second `Branch_Taken` held high in FLUSH is ignored; `Flush_Cnt`=1.
- Branch taken while `haz`=1 → no flush until the stall clears; then the flush occurs.
- `Mem_Busy` high for 3 cycles during a load-use stall → `Pipe_Freeze`=1 for 3 cycles with `Stall`=0. Then RUN resumes the stall sequence. `RST` pulsed during MEMWAIT → RUN, counters 0.
